// File: rtl/gbm_pkg.sv
// Shared types and helpers for the grant/burst mux.
// FSM state encoding and counter width helper.
package gbm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN0    = 2'd1,
        ST_OWN1    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/gnt_burst_mux_if.sv
// Bus bundle for gnt_burst_mux: two clients, arbiter req/gnt,
// shared output stream and error pulse.
interface gnt_burst_mux_if #(
    parameter int DATA_W = 8
);
    logic              cli0_req;
    logic              cli0_valid;
    logic [DATA_W-1:0] cli0_data;
    logic              cli0_last;
    logic              cli0_ready;
    logic              cli1_req;
    logic              cli1_valid;
    logic [DATA_W-1:0] cli1_data;
    logic              cli1_last;
    logic              cli1_ready;
    logic              req_0;
    logic              req_1;
    logic              gnt_0;
    logic              gnt_1;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_src;
    logic              out_ready;
    logic              err;

    modport slave (
        input  cli0_req, cli0_valid, cli0_data, cli0_last,
        input  cli1_req, cli1_valid, cli1_data, cli1_last,
        input  gnt_0, gnt_1, out_ready,
        output cli0_ready, cli1_ready, req_0, req_1,
        output out_valid, out_data, out_last, out_src, err
    );

    modport master (
        output cli0_req, cli0_valid, cli0_data, cli0_last,
        output cli1_req, cli1_valid, cli1_data, cli1_last,
        output gnt_0, gnt_1, out_ready,
        input  cli0_ready, cli1_ready, req_0, req_1,
        input  out_valid, out_data, out_last, out_src, err
    );

endinterface

// File: rtl/gbm_beat_counter.sv
// Clearable up-counter with terminal-count flag; saturates at TC.
// Used for beat counting and the optional idle timeout.
module gbm_beat_counter #(
    parameter int W  = 3,
    parameter int TC = 3
) (
    input  logic clk,
    input  logic nreset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [W-1:0] TCV = W'(TC);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TCV);

endmodule

// File: rtl/gnt_burst_mux.sv
// Routes the granted client's burst onto one shared stream, then releases the arbiter.
// Optional idle-timeout abort enabled by defining GBM_TIMEOUT_EN.
module gnt_burst_mux
    import gbm_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 16
) (
    input logic            clk,
    input logic            nreset,
    gnt_burst_mux_if.slave bus
);

    localparam int CW = cnt_w(MAX_BURST);

    if (MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("gnt_burst_mux: MAX_BURST and TIMEOUT must be >= 1");
    end

    state_t            state;
    logic              err_q;
    logic              own0, own1, own, idle;
    logic              sel_valid, sel_last;
    logic [DATA_W-1:0] mux_data;
    logic              accept, last, done, tmo, dbl;
    logic              beat_tc;

    assign own0 = (state == ST_OWN0);
    assign own1 = (state == ST_OWN1);
    assign own  = own0 | own1;
    assign idle = (state == ST_IDLE);

    always_comb begin
        mux_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        unique case (1'b1)
            own0: begin
                mux_data  = bus.cli0_data;
                sel_valid = bus.cli0_valid;
                sel_last  = bus.cli0_last;
            end
            own1: begin
                mux_data  = bus.cli1_data;
                sel_valid = bus.cli1_valid;
                sel_last  = bus.cli1_last;
            end
            default: ;
        endcase
    end

    assign accept = sel_valid & bus.out_ready;
    assign last   = sel_last | beat_tc;
    assign done   = accept & last;
    assign dbl    = idle & bus.gnt_0 & bus.gnt_1;

    gbm_beat_counter #(
        .W  (CW),
        .TC (MAX_BURST - 1)
    ) u_beat (
        .clk    (clk),
        .nreset (nreset),
        .clr    (~own | done | tmo),
        .inc    (accept & ~last),
        .tc     (beat_tc)
    );

`ifdef GBM_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic idle_tc;

    gbm_beat_counter #(
        .W  (IW),
        .TC (TIMEOUT - 1)
    ) u_idle (
        .clk    (clk),
        .nreset (nreset),
        .clr    (~own | accept),
        .inc    (own & ~accept),
        .tc     (idle_tc)
    );

    // tc on a beatless cycle means TIMEOUT consecutive idle cycles
    assign tmo = own & ~accept & idle_tc;
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
        end else begin
            err_q <= dbl | tmo;
            unique case (state)
                ST_IDLE: begin
                    if (bus.gnt_0) begin
                        state <= ST_OWN0;
                    end else if (bus.gnt_1) begin
                        state <= ST_OWN1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (done | tmo) begin
                        state <= ST_RELEASE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // outputs forced low while reset is asserted
    assign bus.req_0      = nreset & (own0 | (idle & bus.cli0_req));
    assign bus.req_1      = nreset & (own1 | (idle & bus.cli1_req));
    assign bus.out_valid  = nreset & sel_valid;
    assign bus.out_data   = nreset ? mux_data : '0;
    assign bus.out_last   = nreset & own & last;
    assign bus.out_src    = nreset & own1;
    assign bus.cli0_ready = nreset & own0 & bus.out_ready;
    assign bus.cli1_ready = nreset & own1 & bus.out_ready;
    assign bus.err        = nreset & err_q;

endmodule

// File: tb/tb_gnt_burst_mux.sv
// Self-checking bench for gnt_burst_mux: vector table, directed corner
// sequences and a randomized run against a burst-level scoreboard.
module tb_gnt_burst_mux;

    localparam int DW = 8;
    localparam int MB = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic nreset = 1'b0;

    gnt_burst_mux_if #(.DATA_W(DW)) bus ();

    gnt_burst_mux #(
        .DATA_W    (DW),
        .MAX_BURST (MB),
        .TIMEOUT   (TO)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        rn;
        logic        r0, v0, l0;
        logic [7:0]  d0;
        logic        r1, v1, l1;
        logic [7:0]  d1;
        logic        g0, g1, ordy;
        logic [15:0] exp;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ex(logic q0, logic q1, logic ov,
                                       logic [7:0] od, logic ol, logic src,
                                       logic y0, logic y1, logic er);
        return {q0, q1, ov, od, ol, src, y0, y1, er};
    endfunction

    function automatic logic [15:0] outs();
        return {bus.req_0, bus.req_1, bus.out_valid, bus.out_data,
                bus.out_last, bus.out_src, bus.cli0_ready,
                bus.cli1_ready, bus.err};
    endfunction

    task automatic zero_inputs();
        bus.cli0_req = 0; bus.cli0_valid = 0;
        bus.cli0_data = 0; bus.cli0_last = 0;
        bus.cli1_req = 0; bus.cli1_valid = 0;
        bus.cli1_data = 0; bus.cli1_last = 0;
        bus.gnt_0 = 0; bus.gnt_1 = 0; bus.out_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        nreset = 0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1;
    endtask

    task automatic t_table();
        vec_t vt[14];
        vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, ex(0,0,0,8'h00,0,0,0,0,0)};
        vt[1]  = vt[0];
        vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ex(0,0,0,8'h00,0,0,0,0,0)};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ex(1,0,0,8'h00,0,0,0,0,0)};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, ex(1,0,0,8'h00,0,0,0,0,0)};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ex(1,0,1,8'hA1,0,0,1,0,0)};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ex(1,0,1,8'hA2,0,0,1,0,0)};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ex(1,0,1,8'hA3,1,0,1,0,0)};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ex(0,0,0,8'h00,0,0,0,0,0)};
        vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hB1, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b1, 1'b1, 1'b1, ex(1,1,0,8'h00,0,0,0,0,0)};
        vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hB1, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, 1'b1, ex(1,0,1,8'hB1,0,0,1,0,1)};
        vt[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, 1'b1, ex(1,0,1,8'hB2,0,0,1,0,0)};
        vt[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hB3, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, 1'b1, ex(0,0,0,8'h00,0,0,0,0,0)};
        vt[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hB3, 1'b1, 1'b0, 1'b0, 8'hC1, 1'b0, 1'b0, 1'b1, ex(0,1,0,8'h00,0,0,0,0,0)};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            nreset = vt[i].rn;
            bus.cli0_req = vt[i].r0; bus.cli0_valid = vt[i].v0;
            bus.cli0_last = vt[i].l0; bus.cli0_data = vt[i].d0;
            bus.cli1_req = vt[i].r1; bus.cli1_valid = vt[i].v1;
            bus.cli1_last = vt[i].l1; bus.cli1_data = vt[i].d1;
            bus.gnt_0 = vt[i].g0; bus.gnt_1 = vt[i].g1;
            bus.out_ready = vt[i].ordy;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
        end
    endtask

    task automatic t_forced();
        logic [7:0] gd[$];
        logic       gl[$];
        int         gc[$];
        int         idx = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            bus.cli1_req = (idx < 6);
            bus.cli1_valid = (idx < 6);
            bus.cli1_data = 8'h30 + 8'(idx);
            bus.cli1_last = 0;
            bus.out_ready = 1;
            #1 bus.gnt_1 = bus.req_1;
            #1;
            if (gc.size() == MB && c == gc[MB-1] + 1)
                chk("t3_release_req1", 32'(bus.req_1), 0);
            if (bus.out_valid && bus.out_ready) begin
                gd.push_back(bus.out_data);
                gl.push_back(bus.out_last);
                gc.push_back(c);
                idx++;
            end
        end
        chk("t3_beats", gd.size(), 6);
        for (int i = 0; i < gd.size(); i++) begin
            chk($sformatf("t3_data%0d", i), 32'(gd[i]), 32'h30 + i);
            chk($sformatf("t3_last%0d", i), 32'(gl[i]),
                32'((i % MB) == MB - 1));
        end
        if (gc.size() > MB)
            chk("t3_regrant_gap", gc[MB] - gc[MB-1], 3);
    endtask

    task automatic t_backpressure();
        logic [7:0] gd[$];
        logic       gl[$];
        int         idx = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            bus.cli0_req = (idx < 3);
            bus.cli0_valid = (idx < 3);
            bus.cli0_data = 8'hE0 + 8'(idx);
            bus.cli0_last = (idx == 2);
            bus.out_ready = (c % 2 == 0);
            #1 bus.gnt_0 = bus.req_0;
            #1;
            if (bus.out_valid) begin
                chk("t4_ready_mirror", 32'(bus.cli0_ready),
                    32'(bus.out_ready));
                chk("t4_other_ready", 32'(bus.cli1_ready), 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                gd.push_back(bus.out_data);
                gl.push_back(bus.out_last);
                idx++;
            end
        end
        chk("t4_beats", gd.size(), 3);
        for (int i = 0; i < gd.size(); i++) begin
            chk($sformatf("t4_data%0d", i), 32'(gd[i]), 32'hE0 + i);
            chk($sformatf("t4_last%0d", i), 32'(gl[i]), 32'(i == 2));
        end
    endtask

    task automatic t_timeout();
        logic exp_err, exp_req;
        do_reset();
        bus.cli0_req = 1;
        bus.gnt_0 = 1;
        bus.out_ready = 1;
        @(negedge clk);
        bus.gnt_0 = 0;
        for (int k = 0; k < TO + 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
`ifdef GBM_TIMEOUT_EN
            exp_err = (k == TO);
            exp_req = (k != TO);
`else
            exp_err = 0;
            exp_req = 1;
`endif
            chk($sformatf("t6_err_k%0d", k), 32'(bus.err), 32'(exp_err));
            chk($sformatf("t6_req0_k%0d", k), 32'(bus.req_0), 32'(exp_req));
        end
    endtask

    task automatic t_random();
        beat_t      dq0[$], dq1[$], eq0[$], eq1[$];
        beat_t      b;
        int         run = 0;
        logic       cur = 0, gsrc = 0, src, el;
        bit         gap = 0;
        logic       a0, a1;
        logic [6:0] sn = 0;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 8; k++) begin
                int n;
                n = $urandom_range(1, 6);
                for (int j = 0; j < n; j++) begin
                    b.d = {c[0], sn};
                    b.l = (j == n - 1);
                    sn++;
                    if (c == 0) begin dq0.push_back(b); eq0.push_back(b); end
                    else begin dq1.push_back(b); eq1.push_back(b); end
                end
            end
        end
        for (int cy = 0; cy < 4000 && (eq0.size() + eq1.size()) > 0; cy++) begin
            if (cy > 0) @(negedge clk);
            bus.cli0_req = dq0.size() > 0;
            bus.cli0_valid = dq0.size() > 0 && $urandom_range(0, 9) < 7;
            bus.cli0_data = dq0.size() > 0 ? dq0[0].d : 8'h00;
            bus.cli0_last = dq0.size() > 0 ? dq0[0].l : 1'b0;
            bus.cli1_req = dq1.size() > 0;
            bus.cli1_valid = dq1.size() > 0 && $urandom_range(0, 9) < 7;
            bus.cli1_data = dq1.size() > 0 ? dq1[0].d : 8'h00;
            bus.cli1_last = dq1.size() > 0 ? dq1[0].l : 1'b0;
            bus.out_ready = $urandom_range(0, 9) < 8;
            #1;
            bus.gnt_0 = 0;
            bus.gnt_1 = 0;
            if ($urandom_range(0, 3) != 0) begin
                if (bus.req_0 && bus.req_1) begin
                    if ($urandom_range(0, 1) == 1) bus.gnt_1 = 1;
                    else bus.gnt_0 = 1;
                end else if (bus.req_0) bus.gnt_0 = 1;
                else if (bus.req_1) bus.gnt_1 = 1;
            end
            #1;
            if (gap) begin
                chk("rnd_release_req", 32'(gsrc ? bus.req_1 : bus.req_0), 0);
                gap = 0;
            end
            a0 = bus.cli0_valid & bus.cli0_ready;
            a1 = bus.cli1_valid & bus.cli1_ready;
            if (a0 && dq0.size() > 0) void'(dq0.pop_front());
            if (a1 && dq1.size() > 0) void'(dq1.pop_front());
            if (bus.out_valid && bus.out_ready) begin
                src = bus.out_src;
                chk("rnd_beat_pending",
                    32'((src ? eq1.size() : eq0.size()) != 0), 1);
                if ((src ? eq1.size() : eq0.size()) != 0) begin
                    b = src ? eq1.pop_front() : eq0.pop_front();
                    el = b.l || (run + 1 == MB);
                    chk("rnd_data", 32'(bus.out_data), 32'(b.d));
                    chk("rnd_last", 32'(bus.out_last), 32'(el));
                    if (run > 0) chk("rnd_src", 32'(src), 32'(cur));
                    chk("rnd_client_hs", 32'({a1, a0}),
                        src ? 32'd2 : 32'd1);
                    run++;
                    cur = src;
                    if (el) begin
                        run = 0;
                        gap = 1;
                        gsrc = src;
                    end
                end
            end else if (a0 || a1) begin
                chk("rnd_hs_no_beat", 32'({a1, a0}), 0);
            end
        end
        chk("rnd_drained", eq0.size() + eq1.size(), 0);
    endtask

    initial begin
        zero_inputs();
        t_table();
        t_forced();
        t_backpressure();
        t_timeout();
        t_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
